serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. Runs one shared 1-bit add slice (half-adder pair plus carry flop) for WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Used where a full parallel adder is too large; trades latency for area.
- Start/ready/done handshake toward the requester; result registers are held stable between operations.

---
 rtl/serial_add_ctrl_if.sv | 45 ++++
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake/data bundle between a requester and serial_add_ctrl.
//   start  requester -> adder  request pulse, sampled only while ready
//   a, b   requester -> adder  operands, captured on the accepted start edge
//   sub    requester -> adder  subtract select (only with SERIAL_ADD_SUB_EN)
//   ready  adder -> requester  idle, able to accept start
//   busy   adder -> requester  bit-serial add in progress
//   done   adder -> requester  one-cycle pulse, sum/carry valid from then on
//   sum    adder -> requester  result register
//   carry  adder -> requester  carry out of the MSB (no-borrow when subtracting)
// Optional build macro: SERIAL_ADD_SUB_EN adds the sub signal.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output start, a, b, sub,
    input  ready, busy, done, sum, carry
  );
  modport slave (
    input  start, a, b, sub,
    output ready, busy, done, sum, carry
  );
`else
  modport master (
    output start, a, b,
    input  ready, busy, done, sum, carry
  );
  modport slave (
    input  start, a, b,
    output ready, busy, done, sum, carry
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one 1-bit full-add slice plus a carry flop is
// reused for WIDTH cycles, LSB first, to add two WIDTH-bit operands.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  serial_add_ctrl_if.slave (start/a/b[/sub] in, ready/busy/done/sum/carry out)
// Optional build macro: SERIAL_ADD_SUB_EN adds bus.sub; when set, b is inverted
// at capture and the carry starts at 1, giving a-b mod 2^WIDTH.
// Timing: accept edge is edge 0; done is high between edges WIDTH and WIDTH+1.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);

  // WIDTH=1 still needs a 1-bit counter.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             s_bit;
  logic             c_new;
  logic [WIDTH-1:0] b_load;
  logic             c_init;

  // Operand B and carry-in as captured on the accept edge.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load = bus.sub ? ~bus.b : bus.b;
    c_init = bus.sub;
`else
    b_load = bus.b;
    c_init = 1'b0;
`endif
  end

  // Shared 1-bit add slice.
  assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign c_new = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = b_load;
          c_d     = c_init;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        c_d             = c_new;
        res_d           = res_q >> 1;
        res_d[WIDTH-1]  = s_bit;  // after WIDTH shifts the first bit sits at bit 0
        a_sh_d          = a_sh_q >> 1;
        b_sh_d          = b_sh_q >> 1;
        cnt_d           = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = res_d;
          carry_d = c_new;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized
// operations compared against a plain-arithmetic model of the sum.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Last completed result the outputs should be holding.
  logic [W-1:0] exp_sum   = '0;
  logic         exp_carry = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true (W+1)-bit sum, or a + ~b + 1 when subtracting.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sb);
    logic sub_on;
    sub_on = sb & SubEn;
    if (sub_on) return {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Called on a negedge. Runs one operation and checks every cycle of it.
  // hold=1 keeps start high throughout, otherwise start toggles randomly in RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                       input bit hold);
    logic [W:0] full;
    int unsigned waited;
    waited = 0;
    while (!bus.ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_start", 64'(bus.ready), 64'(1));
    if (!bus.ready) return;
    full = model(a, b, sb);
    bus.a     = a;
    bus.b     = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sb;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(W); i++) begin
      check("busy_run", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b010));
      check("sum_hold_run", 64'({bus.carry, bus.sum}), 64'({exp_carry, exp_sum}));
      // Scramble inputs: only the captured copies may matter.
      bus.start = hold | ($urandom_range(0, 1) == 1);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      bus.sub   = ($urandom_range(0, 1) == 1);
`endif
      @(negedge clk);
    end
    check("done_pulse", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b001));
    check("result", 64'({bus.carry, bus.sum}), 64'(full));
    exp_sum   = full[W-1:0];
    exp_carry = full[W];
    if (!hold) bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_done", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b100));
    check("result_held", 64'({bus.carry, bus.sum}), 64'({exp_carry, exp_sum}));
  endtask

  // Start an operation, reset in the middle of RUN, confirm no done follows.
  task automatic abort_op(input logic [W-1:0] a, input logic [W-1:0] b);
    check("ready_before_abort", 64'(bus.ready), 64'(1));
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_abort", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b010));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_sum   = '0;
    exp_carry = 1'b0;
    check("abort_state", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b100));
    check("abort_result", 64'({bus.carry, bus.sum}), 64'(0));
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b100));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_state", 64'({bus.ready, bus.busy, bus.done}), 64'(3'b100));
    check("reset_result", 64'({bus.carry, bus.sum}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_op(W'(3), W'(5), 1'b0, 1'b0);
    do_op(W'(255), W'(1), 1'b0, 1'b0);
    do_op(W'(0), W'(0), 1'b0, 1'b0);
    do_op(W'(8'hA5), W'(8'h5A), 1'b0, 1'b0);
    do_op(W'(8'hF0), W'(8'h3C), 1'b0, 1'b0);

    abort_op(W'(200), W'(100));
    do_op(W'(200), W'(100), 1'b0, 1'b0);

    // Back-to-back with start held: each op must be accepted on the first IDLE cycle.
    for (int i = 0; i < 3; i++) do_op(W'($urandom), W'($urandom), 1'b0, 1'b1);
    bus.start = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    do_op(W'(5), W'(3), 1'b1, 1'b0);
    do_op(W'(3), W'(5), 1'b1, 1'b0);
    do_op(W'(7), W'(7), 1'b1, 1'b0);
`endif

    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1));
    end
    bus.start = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
